stat_response_misr: RTL and testbench
=====================================

// Module: stat_response_misr
// PURPOSE
//  Response-side companion to the generated Stat_* benchmark netlists.
//  Accepts one output vector per pattern from the circuit under test
//  (e.g. the 17 primary outputs n389..n405) over a valid/ready handshake.
//  Compacts a fixed number of vectors into a MISR signature, then compares
//  the signature with a golden value to give a pass/fail verdict.
// PARAMETERS
//  WIDTH         17        response vector / signature width (>=2)
//  NUM_PATTERNS  1024      vectors compacted per run (>=1)
//  POLY          17'h04001 feedback taps, x^WIDTH term omitted (x^17+x^14+1)
//  SEED          17'h00000 signature value loaded at start
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      begin a run (accepted in IDLE or DONE only)
//  resp_valid  in   1      resp_data holds a valid vector
//  resp_ready  out  1      block can accept a vector this cycle
//  resp_data   in   WIDTH  response vector from the circuit under test
//  golden      in   WIDTH  expected signature; sampled on the last accept
//  busy        out  1      high in RUN
//  done        out  1      high in DONE
//  pass        out  1      signature==golden; valid while done=1
//  signature   out  WIDTH  current MISR contents
//  count       out  CW     vectors accepted this run, CW=$clog2(NUM_PATTERNS+1)
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. On reset: state=IDLE, signature=SEED,
//    count=0, pass=0, all control outputs=0. Reset may assert mid-run; the
//    run is abandoned with no residue.
//  - IDLE: resp_ready=0. start=1 -> RUN next cycle; signature<=SEED, count<=0.
//  - RUN: busy=1, resp_ready=1. An accept is resp_valid & resp_ready.
//    The vector is consumed in the same cycle; there is no buffering.
//    On each accept:
//      fb = signature[WIDTH-1];
//      signature <= ({signature[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)) ^ resp_data;
//      count <= count + 1.
//    Without an accept, signature and count hold. start is ignored in RUN.
//  - The accept that brings count to NUM_PATTERNS also does the following:
//    the same edge writes the final signature, sets
//    pass <= (next_signature == golden) and enters DONE. resp_ready is
//    therefore 0 from the next cycle on, and no extra vector is absorbed.
//  - DONE: done=1, busy=0, resp_ready=0. signature, count and pass hold.
//    resp_valid is ignored. start=1 -> RUN: reload SEED, count=0, and pass
//    clears in the same edge.
//  - Latency: the verdict is visible 1 cycle after the final accept.
//  - Width rules: arithmetic is modulo 2 and never widens. count never
//    exceeds NUM_PATTERNS.
// TESTING
//  T1 reset: assert rst mid-RUN after 2 accepts -> state IDLE, signature=0,
//     count=0, resp_ready=0 asynchronously.
//  T2 NUM_PATTERNS=4, SEED=0, 4 accepts of 17'h00001 -> signature sequence
//     1,3,7,F. done=1 the cycle after the 4th accept. golden=17'h0000F
//     -> pass=1.
//  T3 feedback wrap: signature=17'h10000, accept data=0 -> next 17'h04001.
//  T4 backpressure: resp_valid toggles 1,0,0,1,1,0,1 -> only the 4 valid
//     cycles advance count. resp_valid held high in DONE -> count stays 4.
//  T5 golden mismatch: run T2 with golden=17'h0000E -> pass=0, done=1.
//  T6 restart: start pulsed in RUN -> ignored. start in DONE -> RUN,
//     count=0, pass=0, signature=SEED next cycle.

Source files
------------

// File: rtl/stat_response_misr.sv
// Response compactor for the Stat_* benchmark netlists: folds NUM_PATTERNS
// vectors into a MISR signature and compares it against a golden value.
module stat_response_misr #(
    parameter int               WIDTH        = 17,
    parameter int               NUM_PATTERNS = 1024,
    parameter logic [WIDTH-1:0] POLY         = 17'h04001,
    parameter logic [WIDTH-1:0] SEED         = 17'h00000,
    localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             resp_valid_i,
    output logic             resp_ready_o,
    input  logic [WIDTH-1:0] resp_data_i,
    input  logic [WIDTH-1:0] golden_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [WIDTH-1:0] signature_o,
    output logic [CW-1:0]    count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             accept;
    logic [WIDTH-1:0] sigNext;

    assign accept  = (state_q == RUN) && resp_valid_i;
    assign sigNext = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_data_i;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d = sigNext;
                    cnt_d = cnt_q + CW'(1);
                    // The final accept also latches the verdict, so no extra vector slips in.
                    if (cnt_q == CW'(NUM_PATTERNS - 1)) begin
                        state_d = DONE;
                        pass_d  = (sigNext == golden_i);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign resp_ready_o = (state_q == RUN);
    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign pass_o       = pass_q;
    assign signature_o  = sig_q;
    assign count_o      = cnt_q;

endmodule

// File: tb/tb_stat_response_misr.sv
// Self-checking bench for stat_response_misr: directed scenarios plus random
// traffic, all compared against a queue-based signature model.
module tb_stat_response_misr;

    localparam int               W    = 17;
    localparam int               NP   = 4;
    localparam int               CW   = $clog2(NP + 1);
    localparam logic [W-1:0]     POLY = 17'h04001;
    localparam logic [W-1:0]     SEED = 17'h00000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          respValid;
    logic          respReady;
    logic [W-1:0]  respData;
    logic [W-1:0]  golden;
    logic          busy;
    logic          done;
    logic          pass;
    logic [W-1:0]  signature;
    logic [CW-1:0] count;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference: 0 = idle, 1 = running, 2 = finished
    int           refMode = 0;
    logic [W-1:0] accepted[$];
    logic         refPass = 1'b0;

    stat_response_misr #(
        .WIDTH(W), .NUM_PATTERNS(NP), .POLY(POLY), .SEED(SEED)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .resp_valid_i(respValid), .resp_ready_o(respReady),
        .resp_data_i(respData), .golden_i(golden),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .signature_o(signature), .count_o(count)
    );

    always #5 clk = ~clk;

    // Signature as polynomial arithmetic: multiply by x, reduce mod the
    // feedback polynomial, add the vector (GF(2) addition is xor).
    function automatic logic [W-1:0] refSignature();
        longint s = longint'(SEED);
        foreach (accepted[i]) begin
            s = s * 2;
            if (s >= (longint'(1) << W)) s = (s - (longint'(1) << W)) ^ longint'(POLY);
            s = s ^ longint'(accepted[i]);
        end
        return W'(s);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".ready"}, 32'(respReady), 32'(refMode == 1));
        checkOutput({tag, ".busy"},  32'(busy),      32'(refMode == 1));
        checkOutput({tag, ".done"},  32'(done),      32'(refMode == 2));
        checkOutput({tag, ".pass"},  32'(pass),      32'(refMode == 2 && refPass));
        checkOutput({tag, ".sig"},   32'(signature), 32'(refSignature()));
        checkOutput({tag, ".count"}, 32'(count),     32'(accepted.size()));
    endtask

    task automatic applyStimulus(input string tag, input logic st, input logic v,
                                 input logic [W-1:0] d, input logic [W-1:0] g);
        start     = st;
        respValid = v;
        respData  = d;
        golden    = g;
        @(posedge clk);
        case (refMode)
            1: begin
                if (v) begin
                    accepted.push_back(d);
                    if (accepted.size() == NP) begin
                        refPass = (refSignature() == g);
                        refMode = 2;
                    end
                end
            end
            default: begin
                if (st) begin
                    refMode = 1;
                    accepted.delete();
                    refPass = 1'b0;
                end
            end
        endcase
        #1;
        start     = 1'b0;
        respValid = 1'b0;
        checkAll(tag);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        #2;
        refMode = 0;
        accepted.delete();
        refPass = 1'b0;
        checkAll(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] t2Seq[4];
        logic [W-1:0] d;
        logic [W-1:0] g;
        t2Seq = '{17'h00001, 17'h00003, 17'h00007, 17'h0000F};
        rst = 1'b1; start = 1'b0; respValid = 1'b0; respData = '0; golden = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        rst = 1'b0;

        // T1: reset lands mid-run after two accepts
        applyStimulus("t1.start", 1'b1, 1'b0, '0, '0);
        applyStimulus("t1.acc0", 1'b0, 1'b1, 17'h0ABCD, '0);
        applyStimulus("t1.acc1", 1'b0, 1'b1, 17'h13579, '0);
        doReset("t1.rst");
        checkOutput("t1.sig0", 32'(signature), 32'h0);

        // T2: four vectors of 1 give 1,3,7,F and a matching verdict
        applyStimulus("t2.start", 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t2.acc", 1'b0, 1'b1, 17'h00001, 17'h0000F);
            checkOutput("t2.seq", 32'(signature), 32'(t2Seq[i]));
        end
        checkOutput("t2.done", 32'(done), 32'h1);
        checkOutput("t2.pass", 32'(pass), 32'h1);

        // T6: restart out of DONE clears everything
        applyStimulus("t6.restart", 1'b1, 1'b0, '0, '0);
        checkOutput("t6.pass0", 32'(pass), 32'h0);

        // T5: same run, wrong golden
        for (int i = 0; i < 4; i++)
            applyStimulus("t5.acc", 1'b0, 1'b1, 17'h00001, 17'h0000E);
        checkOutput("t5.pass", 32'(pass), 32'h0);
        checkOutput("t5.done", 32'(done), 32'h1);

        // T3: top bit set, zero data -> feedback taps appear
        applyStimulus("t3.start", 1'b1, 1'b0, '0, '0);
        applyStimulus("t3.acc0", 1'b0, 1'b1, 17'h10000, '0);
        applyStimulus("t3.acc1", 1'b0, 1'b1, 17'h00000, '0);
        checkOutput("t3.wrap", 32'(signature), 32'h04001);
        applyStimulus("t3.acc2", 1'b0, 1'b1, 17'h00000, '0);
        applyStimulus("t3.acc3", 1'b0, 1'b1, 17'h00000, '0);

        // T4: backpressure, plus a start pulse in RUN that must be ignored
        applyStimulus("t4.start", 1'b1, 1'b0, '0, '0);
        begin
            logic vPat[7];
            vPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 7; i++)
                applyStimulus("t4.bp", (i == 2), vPat[i], W'($urandom), '0);
        end
        checkOutput("t4.count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++)
            applyStimulus("t4.held", 1'b0, 1'b1, W'($urandom), '0);
        checkOutput("t4.countHeld", 32'(count), 32'd4);

        // Random traffic; half the finishing accepts use a matching golden
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                doReset("rnd.rst");
            end else begin
                d = W'($urandom);
                g = W'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    accepted.push_back(d);
                    g = refSignature();
                    void'(accepted.pop_back());
                end
                applyStimulus("rnd", ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), d, g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
